// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle for serial_frame_tx: the producer drives din/din_valid,
// the transmitter drives the ready flag, the serial line and its strobes.
interface serial_frame_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             shift_en;
  logic             busy;
  logic             frame_done;

  // A word transfers on a rising edge where din_valid and din_ready are both high;
  // din_valid may rise at any time, din_ready never depends on din_valid.
  modport master (
    output din, din_valid,
    input  din_ready, ser_out, shift_en, busy, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, shift_en, busy, frame_done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed MSB-first parallel-to-serial transmitter with a per-bit shift strobe.
// Optional macro PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module serial_frame_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic                clk,
  input  logic                reset,
  serial_frame_tx_if.slave    bus,
  output logic [2:0]          dbg_state_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (DIV < 1) begin : g_div_check
    $error("serial_frame_tx: DIV must be at least 1");
  end
  if (WIDTH < 1) begin : g_width_check
    $error("serial_frame_tx: WIDTH must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             ser_q, ser_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_cnt;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  assign last_cnt = (cnt_q == CW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    if (state_q == S_IDLE) begin
      if (bus.din_valid) begin
        state_d = S_START;
        cnt_d   = '0;
        idx_d   = '0;
        sreg_d  = bus.din;
`ifdef PARITY_EN
        par_d   = ^bus.din;
`endif
      end
    end else begin
      cnt_d = last_cnt ? '0 : cnt_q + CW'(1);
      if (last_cnt) begin
        case (state_q)
          S_START: state_d = S_DATA;
          S_DATA: begin
            sreg_d = sreg_q << 1;
            if (idx_q == IW'(WIDTH - 1)) begin
              idx_d = '0;
`ifdef PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
`ifdef PARITY_EN
          S_PARITY: state_d = S_STOP;
`endif
          S_STOP:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with the state they describe.
  always_comb begin
    ser_d = 1'b1;
    case (state_d)
      S_START:  ser_d = 1'b0;
      S_DATA:   ser_d = sreg_d[WIDTH-1];
`ifdef PARITY_EN
      S_PARITY: ser_d = par_d;
`endif
      default:  ser_d = 1'b1;
    endcase
    shift_d = (state_d == S_DATA) && (cnt_d == CW'(DIV - 1));
    done_d  = (state_d == S_STOP) && (cnt_d == CW'(DIV - 1));
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      ser_q   <= 1'b1;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      ser_q   <= ser_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.din_ready  = (state_q == S_IDLE);
  assign bus.ser_out    = ser_q;
  assign bus.shift_en   = shift_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one DIV=1 and one DIV=3 instance, parity-aware when PARITY_EN is defined.
module tb_serial_frame_tx;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk;
  logic rst;
  logic [2:0] a_dbg, b_dbg;
  logic [3:0] ds_a;
  int checks = 0;
  int errors = 0;

  serial_frame_tx_if #(.WIDTH(4)) a_if ();
  serial_frame_tx_if #(.WIDTH(4)) b_if ();

  serial_frame_tx #(.WIDTH(4), .DIV(1)) dut_a (
    .clk(clk), .reset(rst), .bus(a_if.slave), .dbg_state_o(a_dbg)
  );
  serial_frame_tx #(.WIDTH(4), .DIV(3)) dut_b (
    .clk(clk), .reset(rst), .bus(b_if.slave), .dbg_state_o(b_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream 4-bit shift-left register fed by instance A
  always @(posedge clk) begin
    if (rst) ds_a <= 4'b0000;
    else if (a_if.shift_en) ds_a <= {ds_a[2:0], a_if.ser_out};
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected {ser_out, shift_en, frame_done, busy} in frame cycle cyc (acceptance at edge 0)
  function automatic logic [3:0] exp_out(input int cyc, input logic [3:0] w, input int div);
    int p;
    logic last, ser, sh, dn;
    p    = (cyc - 1) / div;
    last = (((cyc - 1) % div) == div - 1);
    sh   = 1'b0;
    dn   = 1'b0;
    if (p == 0) ser = 1'b0;
    else if (p <= 4) begin
      ser = w[4 - p];
      sh  = last;
    end else if (PAR == 1 && p == 5) ser = ^w;
    else begin
      ser = 1'b1;
      dn  = last;
    end
    return {ser, sh, dn, 1'b1};
  endfunction

  function automatic logic [3:0] obs_out(input bit sel);
    if (sel) return {b_if.ser_out, b_if.shift_en, b_if.frame_done, b_if.busy};
    return {a_if.ser_out, a_if.shift_en, a_if.frame_done, a_if.busy};
  endfunction

  // driver: present w with valid while idle; returns #1 into frame cycle 1
  task automatic accept(input bit sel, input logic [3:0] w);
    if (sel) begin b_if.din = w; b_if.din_valid = 1'b1; end
    else     begin a_if.din = w; a_if.din_valid = 1'b1; end
    @(posedge clk); #1;
  endtask

  // checks frame cycles 1..L, ending inside cycle L
  task automatic trace(input bit sel, input logic [3:0] w, input int div, input string name);
    int len;
    len = (4 + 2 + PAR) * div;
    for (int c = 1; c <= len; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      chk($sformatf("%s_c%0d", name, c), {4'b0, obs_out(sel)}, {4'b0, exp_out(c, w, div)});
    end
  endtask

  task automatic check_idle(input bit sel, input string name);
    if (sel) chk(name, {3'b0, b_if.ser_out, b_if.shift_en, b_if.frame_done, b_if.busy, b_if.din_ready}, 8'b0001_0001);
    else     chk(name, {3'b0, a_if.ser_out, a_if.shift_en, a_if.frame_done, a_if.busy, a_if.din_ready}, 8'b0001_0001);
  endtask

  initial begin
    rst = 1'b1;
    a_if.din = 4'h0; a_if.din_valid = 1'b0;
    b_if.din = 4'h0; b_if.din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle(0, "reset_a");
    check_idle(1, "reset_b");
    chk("reset_dbg_a", {5'b0, a_dbg}, 8'd0);
    chk("reset_dbg_b", {5'b0, b_dbg}, 8'd0);
    chk("reset_ds", {4'b0, ds_a}, 8'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle(0, "idle_a");

    // basic frame 1011, din scrambled right after acceptance
    accept(0, 4'b1011);
    a_if.din_valid = 1'b0;
    a_if.din = 4'b0100;
    chk("dbg_start", {5'b0, a_dbg}, 8'd1);
    trace(0, 4'b1011, 1, "f1011");
    @(posedge clk); #1;
    check_idle(0, "after_f1011");
    chk("ds_1011", {4'b0, ds_a}, 8'h0B);

    // more data patterns, including even parity of 0 and all-ones
    accept(0, 4'b1001);
    a_if.din_valid = 1'b0;
    trace(0, 4'b1001, 1, "f1001");
    @(posedge clk); #1;
    chk("ds_1001", {4'b0, ds_a}, 8'h09);
    accept(0, 4'b1111);
    a_if.din_valid = 1'b0;
    trace(0, 4'b1111, 1, "f1111");
    @(posedge clk); #1;
    chk("ds_1111", {4'b0, ds_a}, 8'h0F);
    accept(0, 4'b0000);
    a_if.din_valid = 1'b0;
    trace(0, 4'b0000, 1, "f0000");
    @(posedge clk); #1;
    check_idle(0, "after_f0000");

    // divider instance: 0110 with DIV=3
    accept(1, 4'b0110);
    b_if.din_valid = 1'b0;
    b_if.din = 4'b1001;
    trace(1, 4'b0110, 3, "div3");
    @(posedge clk); #1;
    check_idle(1, "after_div3");

    // reset in cycle 3 of a DIV=1 frame
    accept(0, 4'b1101);
    a_if.din_valid = 1'b0;
    chk("rst_c1", {4'b0, obs_out(0)}, {4'b0, exp_out(1, 4'b1101, 1)});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_c3", {4'b0, obs_out(0)}, {4'b0, exp_out(3, 4'b1101, 1)});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle(0, "rst_c4");
    chk("rst_dbg", {5'b0, a_dbg}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_idle(0, $sformatf("rst_quiet_%0d", i));
    end

    // back-to-back with din_valid held and din changed after acceptance
    accept(0, 4'b1010);
    a_if.din = 4'b0101;
    trace(0, 4'b1010, 1, "b2b_1");
    @(posedge clk); #1;
    check_idle(0, "b2b_gap");
    chk("ds_b2b_1", {4'b0, ds_a}, 8'h0A);
    @(posedge clk); #1;
    a_if.din_valid = 1'b0;
    a_if.din = 4'b1111;
    trace(0, 4'b0101, 1, "b2b_2");
    @(posedge clk); #1;
    check_idle(0, "b2b_end");
    chk("ds_b2b_2", {4'b0, ds_a}, 8'h05);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter that sits directly upstream of the team's 4-bit serial-in shift register. It accepts a WIDTH-bit word over a valid/ready handshake and emits it on a single serial line, MSB first, framed by a start bit and a stop bit. It provides a per-bit shift strobe, so a left-shifting register that inserts new bits at the LSB holds the word in its original order once the frame completes.

## Interface
- WIDTH, 4: data bits per frame (≥1).
- DIV, 1: clock cycles per serial bit period (≥1). DIV=0 is an elaboration error.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to send; sampled only on the acceptance edge.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word; high only in IDLE.
- ser_out  output  1  serial line; idle level 1.
- shift_en  output  1  one-cycle strobe per data bit for the downstream register.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse at the end of a frame.

## Operation
- The FSM has four states: IDLE, START, DATA, STOP. PARITY is a fifth state, present only with PARITY_EN.
- Acceptance occurs on a rising edge with din_valid=1 and din_ready=1.
  - din is copied into an internal WIDTH-bit shift register.
  - The bit-period counter and bit index are cleared.
  - The FSM moves IDLE→START.
- Bit-period counter: 0..DIV-1. Each state holds for DIV cycles, then advances.
- Line level by state:
  - IDLE: ser_out=1.
  - START: ser_out=0.
  - DATA: ser_out = current MSB of the internal register. The register shifts left after each bit period.
  - STOP: ser_out=1.
- DATA lasts WIDTH bit periods. The bit index runs 0..WIDTH-1 and wraps to STOP after index WIDTH-1.
- shift_en is 1 only in the last cycle (counter=DIV-1) of each DATA bit period. It pulses exactly WIDTH times per frame, and ser_out is stable in the same cycle.
- frame_done=1 only in the last cycle of STOP. The next state is IDLE.
- Changes on din or din_valid after acceptance are ignored until IDLE.
- All outputs are registered, except din_ready, which is decoded from the state.

## Timing
- Reset values: state=IDLE, ser_out=1, shift_en=0, busy=0, frame_done=0, din_ready=1, counters=0, internal register=0.
- Reset mid-frame aborts the frame. On the next edge all reset values apply. No frame_done and no further shift_en pulses.
- Reset has priority over acceptance when both are asserted on the same edge.
- Frame cycle counts, with acceptance at edge 0:
  - START occupies cycles 1..DIV.
  - Data bit k occupies cycles (1+k)·DIV+1 .. (2+k)·DIV.
  - STOP occupies the final DIV cycles.
- Total frame length is (WIDTH+2)·DIV cycles, or (WIDTH+3)·DIV with PARITY_EN.
- din_ready rises on the cycle after the frame_done cycle. Consecutive frames are therefore separated by at least one IDLE cycle (ser_out=1).
- If din_valid is held high continuously, a new frame is accepted on the first IDLE edge.

## Configuration
- PARITY_EN defined:
  - A PARITY state of DIV cycles is inserted between DATA and STOP.
  - ser_out = XOR of the accepted word (even parity).
  - shift_en stays 0 in PARITY.
  - frame_done timing shifts later by DIV cycles.
- PARITY_EN undefined: PARITY state and parity logic are absent; DATA goes directly to STOP.

## Test plan
- Basic frame (WIDTH=4, DIV=1, no parity): send 4'b1011.
  - ser_out over cycles 1–6 = 0,1,0,1,1,1.
  - shift_en=1 in cycles 2–5.
  - frame_done=1 in cycle 6; din_ready=1 in cycle 7.
  - A downstream shift-left register holds 4'b1011 after cycle 5.
- Parity (PARITY_EN, DIV=1):
  - Send 4'b1011: parity bit 1 in cycle 6, STOP in cycle 7, frame_done in cycle 7.
  - Send 4'b1001: parity bit 0.
- Divider (DIV=3): send 4'b0110.
  - Each level is held for 3 cycles.
  - shift_en occurs in cycles 6, 9, 12 and 15.
  - frame_done in cycle 18.
- Reset mid-frame: assert reset in cycle 3 of a DIV=1 frame.
  - Next cycle: ser_out=1, busy=0, din_ready=1.
  - No frame_done.
  - No shift_en after the reset edge.
- Back-to-back and input stability: hold din_valid=1 and change din after acceptance.
  - The first frame carries the originally accepted word.
  - The second acceptance occurs in the IDLE cycle following frame_done.
  - The gap between the two frames is exactly one ser_out=1 idle cycle.
